// File: rtl/pulse_meter.sv
// Receive-side checker for a periodic pulse train: measures high width and period,
// compares them against expected values, and tracks lock, mismatch, loss of signal and overflow.
module pulse_meter #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned EXP_HIGH   = 19,
   parameter int unsigned EXP_PERIOD = 200,
   parameter int unsigned TOL        = 1,
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] width_o,
   output logic [CNT_W-1:0] period_o,
   output logic             meas_valid,
   output logic             locked,
   output logic             mismatch,
   output logic             timeout,
   output logic             ovf
);

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   localparam int unsigned      McW     = $clog2(LOCK_CNT + 1);
   localparam logic [McW-1:0]   McOne   = McW'(1);
   localparam logic [McW-1:0]   LockMax = McW'(LOCK_CNT);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax  = '1;

   state_e           state_q;
   logic             s1_q, s2_q, prev_q;
   logic [CNT_W-1:0] per_cnt_q, hi_cnt_q;
   logic [McW-1:0]   match_cnt_q;

   logic rise, per_sat, hi_sat, per_expired, is_match;

   // Differences are taken one bit wider than the counters so they never wrap.
   function automatic logic within_tol(input logic [CNT_W-1:0] val, input int unsigned target);
      logic [CNT_W:0] v, t, d;
      v = {1'b0, val};
      t = (CNT_W+1)'(target);
      d = (v >= t) ? v - t : t - v;
      return d <= (CNT_W+1)'(TOL);
   endfunction

   always_comb begin
      rise        = s2_q & ~prev_q;
      per_sat     = (per_cnt_q == CntMax);
      hi_sat      = (hi_cnt_q == CntMax);
      per_expired = (64'(per_cnt_q) == 64'(TIMEOUT));
      is_match    = within_tol(hi_cnt_q, EXP_HIGH) && within_tol(per_cnt_q, EXP_PERIOD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         prev_q      <= 1'b0;
         per_cnt_q   <= '0;
         hi_cnt_q    <= '0;
         match_cnt_q <= '0;
         width_o     <= '0;
         period_o    <= '0;
         meas_valid  <= 1'b0;
         locked      <= 1'b0;
         mismatch    <= 1'b0;
         timeout     <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         s1_q       <= pulse_in;
         s2_q       <= s1_q;
         prev_q     <= s2_q;
         meas_valid <= 1'b0;
         mismatch   <= 1'b0;
         timeout    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // First edge after reset or loss of signal only starts a measurement.
               if (rise) begin
                  per_cnt_q <= CntOne;
                  hi_cnt_q  <= CntOne;
                  state_q   <= StHigh;
               end
            end
            StHigh, StLow: begin
               if (rise) begin
                  width_o    <= hi_cnt_q;
                  period_o   <= per_cnt_q;
                  meas_valid <= 1'b1;
                  if (is_match) begin
                     if (match_cnt_q >= LockMax - McOne) begin
                        match_cnt_q <= LockMax;
                        locked      <= 1'b1;
                     end else begin
                        match_cnt_q <= match_cnt_q + McOne;
                     end
                  end else begin
                     match_cnt_q <= '0;
                     locked      <= 1'b0;
                     mismatch    <= 1'b1;
                  end
                  per_cnt_q <= CntOne;
                  hi_cnt_q  <= CntOne;
                  state_q   <= StHigh;
               end else if (per_expired) begin
                  timeout     <= 1'b1;
                  locked      <= 1'b0;
                  match_cnt_q <= '0;
                  state_q     <= StIdle;
               end else begin
                  if (per_sat) ovf <= 1'b1;
                  else         per_cnt_q <= per_cnt_q + CntOne;
                  if (state_q == StHigh) begin
                     if (!s2_q)       state_q <= StLow;
                     else if (hi_sat) ovf <= 1'b1;
                     else             hi_cnt_q <= hi_cnt_q + CntOne;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: random and directed pulse trains scored against
// an arithmetic model of width/period/lock behaviour.
module tb_pulse_meter;

   localparam int EXP_H = 19;
   localparam int EXP_P = 200;
   localparam int TOL   = 1;
   localparam int LOCK  = 4;

   logic clk = 1'b0, rst = 1'b1, pulse_in = 1'b0, pulse8 = 1'b0;
   logic [15:0] width_o, period_o;
   logic meas_valid, locked, mismatch, timeout, ovf;
   logic [7:0] width8, period8;
   logic mv8, locked8, mm8, to8, ovf8;

   int total = 0, bad = 0;
   int unsigned cyc = 0;

   typedef struct packed {logic [15:0] w; logic [15:0] p; logic mm; logic lk;} rep_t;
   rep_t got_q[$], exp_q[$];
   int unsigned mv_cyc_q[$], to_cyc_q[$], rise_q[$];
   int tr_h[$], tr_p[$];
   int unsigned w8_q[$], p8_q[$];
   logic ovf8_q[$];

   pulse_meter u_dut (
      .clk(clk), .rst(rst), .pulse_in(pulse_in), .width_o(width_o), .period_o(period_o),
      .meas_valid(meas_valid), .locked(locked), .mismatch(mismatch), .timeout(timeout), .ovf(ovf)
   );

   pulse_meter #(.CNT_W(8), .TIMEOUT(1024)) u_dut8 (
      .clk(clk), .rst(rst), .pulse_in(pulse8), .width_o(width8), .period_o(period8),
      .meas_valid(mv8), .locked(locked8), .mismatch(mm8), .timeout(to8), .ovf(ovf8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (meas_valid) begin
         got_q.push_back({width_o, period_o, mismatch, locked});
         mv_cyc_q.push_back(cyc);
      end
      if (timeout) to_cyc_q.push_back(cyc);
      if (meas_valid || timeout) begin
         total++;
         if (meas_valid && timeout) begin
            bad++;
            $display("FAIL strobe_excl meas_valid=%b timeout=%b required not both", meas_valid,
                     timeout);
         end
      end
      if (mv8) begin
         w8_q.push_back(32'(width8));
         p8_q.push_back(32'(period8));
         ovf8_q.push_back(ovf8);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      pulse_in = 1'b0;
      pulse8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      got_q.delete(); mv_cyc_q.delete(); to_cyc_q.delete(); rise_q.delete();
      tr_h.delete(); tr_p.delete();
      w8_q.delete(); p8_q.delete(); ovf8_q.delete();
   endtask

   function automatic void add(input int h, input int p);
      tr_h.push_back(h);
      tr_p.push_back(p);
   endfunction

   // Each rise reports the pulse before it; the first pulse of a train is never reported.
   function automatic void build_exp();
      int  mc, w, p;
      bit  ok;
      rep_t r;
      mc = 0;
      exp_q.delete();
      for (int k = 1; k < tr_h.size(); k++) begin
         w = (tr_h[k-1] > 65535) ? 65535 : tr_h[k-1];
         p = (tr_p[k-1] > 65535) ? 65535 : tr_p[k-1];
         ok = (w >= EXP_H - TOL) && (w <= EXP_H + TOL) && (p >= EXP_P - TOL) && (p <= EXP_P + TOL);
         mc = ok ? ((mc < LOCK) ? mc + 1 : LOCK) : 0;
         r.w = 16'(w);
         r.p = 16'(p);
         r.mm = !ok;
         r.lk = ok && (mc == LOCK);
         exp_q.push_back(r);
      end
   endfunction

   task automatic send_train(input int from);
      for (int k = from; k < tr_h.size(); k++) begin
         rise_q.push_back(cyc);
         pulse_in = 1'b1;
         repeat (tr_h[k]) @(negedge clk);
         pulse_in = 1'b0;
         repeat (tr_p[k] - tr_h[k]) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({width_o, period_o, meas_valid, locked, mismatch, timeout, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_main got w=%0d p=%0d mv=%b lk=%b mm=%b to=%b ovf=%b required all 0",
                  width_o, period_o, meas_valid, locked, mismatch, timeout, ovf);
      end
      total++;
      if ({width8, period8, mv8, locked8, mm8, to8, ovf8} !== '0) begin
         bad++;
         $display("FAIL reset_dut8 got w=%0d p=%0d ovf=%b required all 0", width8, period8, ovf8);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      total++;
      if (got_q.size() != 0 || to_cyc_q.size() != 0) begin
         bad++;
         $display("FAIL reset_quiet got reports=%0d timeouts=%0d required 0 0", got_q.size(),
                  to_cyc_q.size());
      end
   endtask

   task automatic test_lock();
      do_reset();
      repeat (6) add(EXP_H, EXP_P);
      build_exp();
      send_train(0);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL lock_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL lock_rep%0d got w=%0d p=%0d mm=%b lk=%b required w=%0d p=%0d mm=%b lk=%b",
                     i, got_q[i].w, got_q[i].p, got_q[i].mm, got_q[i].lk,
                     exp_q[i].w, exp_q[i].p, exp_q[i].mm, exp_q[i].lk);
         end
      end
      if (mv_cyc_q.size() > 0 && rise_q.size() > 1) begin
         total++;
         if (mv_cyc_q[0] != rise_q[1] + 3) begin
            bad++;
            $display("FAIL lock_latency got cycle=%0d required=%0d", mv_cyc_q[0], rise_q[1] + 3);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      repeat (12) add(int'($urandom_range(16, 22)), int'($urandom_range(197, 203)));
      build_exp();
      send_train(0);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rand_rep%0d got w=%0d p=%0d mm=%b lk=%b required w=%0d p=%0d mm=%b lk=%b",
                     i, got_q[i].w, got_q[i].p, got_q[i].mm, got_q[i].lk,
                     exp_q[i].w, exp_q[i].p, exp_q[i].mm, exp_q[i].lk);
         end
      end
   endtask

   task automatic test_mismatch();
      do_reset();
      repeat (5) add(EXP_H, EXP_P);
      add(EXP_H, EXP_P + 2);
      repeat (5) add(EXP_H, EXP_P);
      build_exp();
      send_train(0);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL mism_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL mism_rep%0d got w=%0d p=%0d mm=%b lk=%b required w=%0d p=%0d mm=%b lk=%b",
                     i, got_q[i].w, got_q[i].p, got_q[i].mm, got_q[i].lk,
                     exp_q[i].w, exp_q[i].p, exp_q[i].mm, exp_q[i].lk);
         end
      end
   endtask

   task automatic test_timeout_low();
      do_reset();
      repeat (5) add(EXP_H, EXP_P);
      build_exp();
      send_train(0);
      repeat (1000) @(negedge clk);
      total++;
      if (got_q.size() != exp_q.size() || to_cyc_q.size() != 1) begin
         bad++;
         $display("FAIL tlow_counts got reports=%0d timeouts=%0d required %0d 1", got_q.size(),
                  to_cyc_q.size(), exp_q.size());
      end else begin
         total++;
         if (to_cyc_q[0] - mv_cyc_q[$] != 1024) begin
            bad++;
            $display("FAIL tlow_delay got=%0d required=1024", to_cyc_q[0] - mv_cyc_q[$]);
         end
      end
      total++;
      if (locked !== 1'b0 || width_o !== 16'(EXP_H) || period_o !== 16'(EXP_P)) begin
         bad++;
         $display("FAIL tlow_after got lk=%b w=%0d p=%0d required lk=0 w=%0d p=%0d", locked,
                  width_o, period_o, EXP_H, EXP_P);
      end
      got_q.delete(); tr_h.delete(); tr_p.delete();
      repeat (2) add(EXP_H, EXP_P);
      build_exp();
      send_train(0);
      total++;
      if (got_q.size() != 1) begin
         bad++;
         $display("FAIL tlow_resume_count got=%0d required=1", got_q.size());
      end else begin
         total++;
         if (got_q[0] !== exp_q[0]) begin
            bad++;
            $display("FAIL tlow_resume got w=%0d p=%0d mm=%b lk=%b required w=%0d p=%0d mm=%b lk=%b",
                     got_q[0].w, got_q[0].p, got_q[0].mm, got_q[0].lk,
                     exp_q[0].w, exp_q[0].p, exp_q[0].mm, exp_q[0].lk);
         end
      end
   endtask

   task automatic test_timeout_high();
      do_reset();
      repeat (3) add(EXP_H, EXP_P);
      add(1100, 1150);
      build_exp();
      send_train(0);
      total++;
      if (got_q.size() != exp_q.size() || to_cyc_q.size() != 1) begin
         bad++;
         $display("FAIL thigh_counts got reports=%0d timeouts=%0d required %0d 1", got_q.size(),
                  to_cyc_q.size(), exp_q.size());
      end else begin
         total++;
         if (to_cyc_q[0] - mv_cyc_q[$] != 1024) begin
            bad++;
            $display("FAIL thigh_delay got=%0d required=1024", to_cyc_q[0] - mv_cyc_q[$]);
         end
      end
      got_q.delete(); tr_h.delete(); tr_p.delete();
      repeat (3) add(EXP_H, EXP_P);
      build_exp();
      send_train(0);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL thigh_resume_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL thigh_rep%0d got w=%0d p=%0d mm=%b lk=%b required w=%0d p=%0d mm=%b lk=%b",
                     i, got_q[i].w, got_q[i].p, got_q[i].mm, got_q[i].lk,
                     exp_q[i].w, exp_q[i].p, exp_q[i].mm, exp_q[i].lk);
         end
      end
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("FAIL thigh_ovf got=%b required=0", ovf);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      repeat (5) add(EXP_H, EXP_P);
      send_train(0);
      total++;
      if (locked !== 1'b1) begin
         bad++;
         $display("FAIL rmid_prelock got=%b required=1", locked);
      end
      pulse_in = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({width_o, period_o, meas_valid, locked, mismatch, timeout, ovf} !== '0) begin
         bad++;
         $display("FAIL rmid_zero got w=%0d p=%0d mv=%b lk=%b mm=%b to=%b ovf=%b required all 0",
                  width_o, period_o, meas_valid, locked, mismatch, timeout, ovf);
      end
      got_q.delete(); tr_h.delete(); tr_p.delete();
      // The synchroniser refills after reset, so the rest of the pulse looks like a new 13/194 one.
      add(13, 194);
      repeat (3) add(EXP_H, EXP_P);
      build_exp();
      repeat (13) @(negedge clk);
      pulse_in = 1'b0;
      repeat (181) @(negedge clk);
      send_train(1);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL rmid_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rmid_rep%0d got w=%0d p=%0d mm=%b lk=%b required w=%0d p=%0d mm=%b lk=%b",
                     i, got_q[i].w, got_q[i].p, got_q[i].mm, got_q[i].lk,
                     exp_q[i].w, exp_q[i].p, exp_q[i].mm, exp_q[i].lk);
         end
      end
   endtask

   task automatic test_short();
      do_reset();
      repeat (6) add(1, 10);
      build_exp();
      send_train(0);
      total++;
      if (got_q.size() != 5) begin
         bad++;
         $display("FAIL short_count got=%0d required=5", got_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL short_rep%0d got w=%0d p=%0d mm=%b lk=%b required w=%0d p=%0d mm=%b lk=%b",
                     i, got_q[i].w, got_q[i].p, got_q[i].mm, got_q[i].lk,
                     exp_q[i].w, exp_q[i].p, exp_q[i].mm, exp_q[i].lk);
         end
      end
   endtask

   task automatic test_ovf();
      do_reset();
      repeat (3) begin
         pulse8 = 1'b1;
         repeat (EXP_H) @(negedge clk);
         pulse8 = 1'b0;
         repeat (300 - EXP_H) @(negedge clk);
      end
      total++;
      if (w8_q.size() != 2) begin
         bad++;
         $display("FAIL ovf_count got=%0d required=2", w8_q.size());
      end
      foreach (w8_q[i]) begin
         total++;
         if (w8_q[i] != EXP_H || p8_q[i] != 255 || ovf8_q[i] !== 1'b1) begin
            bad++;
            $display("FAIL ovf_rep%0d got w=%0d p=%0d ovf=%b required w=%0d p=255 ovf=1", i,
                     w8_q[i], p8_q[i], ovf8_q[i], EXP_H);
         end
      end
      total++;
      if (ovf8 !== 1'b1 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_sticky got dut8=%b main=%b required 1 0", ovf8, ovf);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_random();
      test_mismatch();
      test_timeout_low();
      test_timeout_high();
      test_reset_mid();
      test_short();
      test_ovf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
